// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types, constants and region helper for the fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_ISR  = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  ISR_REGION = 4'hC;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // True when pc lies in the 256 MiB region selected by the top nibble.
  function automatic logic in_region(input logic [31:0] pc, input logic [3:0] region);
    return pc[31:28] == region;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_sel.sv
// ============================================================================
// Module : fetch_pc_sel
// Brief  : Next-PC priority mux (interrupt > redirect > sequential) and the
//          interrupt-take decision.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_pc_sel #(
  parameter logic [31:0] ISR_BASE = 32'hC000_0000
) (
  input  logic        is_fill,
  input  logic        is_run,
  input  logic [31:0] pc_q,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        intr_req,
  output logic [31:0] pc_next,
  output logic        take_intr
);

  always_comb begin
    // A redirect owns this cycle as a branch with a delay slot, so entry waits.
    take_intr = is_run && intr_req && !stall && !redirect_valid;
    pc_next   = pc_q + 32'd4;
    if (is_fill) begin
      pc_next = pc_q;
    end else if (take_intr) begin
      pc_next = ISR_BASE;
    end else if (redirect_valid) begin
      pc_next = redirect_pc & ~32'h0000_0003;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch stage: PC ownership, imem/ISR ROM addressing,
//          interrupt entry with EPC capture and ISR exit on jump-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ISR_BASE = {ISR_REGION, 28'h000_0000}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        intr_req,
  output logic [29:0] imem_addr,
  output logic [29:0] isr_addr,
  input  logic [31:0] imem_inst,
  input  logic [31:0] isr_inst,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        in_isr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  epc_q, epc_d;
  logic         inst_valid_q, inst_valid_d;
  logic         epc_we_q, epc_we_d;
  logic [31:0]  pc_next;
  logic         take_intr;

  fetch_pc_sel #(
    .ISR_BASE (ISR_BASE)
  ) u_pc_sel (
    .is_fill        (state_q == ST_FILL),
    .is_run         (state_q == ST_RUN),
    .pc_q           (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .intr_req       (intr_req),
    .pc_next        (pc_next),
    .take_intr      (take_intr)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    inst_valid_d = inst_valid_q;
    epc_we_d     = 1'b0;
    if (!stall) begin
      pc_d = pc_next;
      case (state_q)
        ST_FILL: begin
          state_d      = ST_RUN;
          inst_valid_d = 1'b1;
        end
        ST_RUN: begin
          if (take_intr) begin
            state_d  = ST_ISR;
            epc_d    = pc_q;
            epc_we_d = 1'b1;
          end
        end
        ST_ISR: begin
          // Leaving the region is the handler's return jump.
          if (redirect_valid && !in_region(redirect_pc, ISR_BASE[31:28])) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      pc_q         <= RESET_PC;
      epc_q        <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      epc_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      inst_valid_q <= inst_valid_d;
      epc_we_q     <= epc_we_d;
    end
  end

  // While stalled the memories re-latch the current word so data holds.
  assign imem_addr  = stall ? pc_q[31:2] : pc_next[31:2];
  assign isr_addr   = imem_addr;
  assign inst_valid = inst_valid_q && !take_intr;
  assign inst       = !inst_valid ? NOP :
                      (in_region(pc_q, ISR_BASE[31:28]) ? isr_inst : imem_inst);
  assign inst_pc    = pc_q;
  assign epc        = epc_q;
  assign epc_we     = epc_we_q;
  assign in_isr     = (state_q == ST_ISR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench for fetch_unit against a cycle-level model of
//          the fetch rules, with registered imem / ISR ROM models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, intr_req;
  logic [31:0] redirect_pc;
  logic [29:0] imem_addr, isr_addr;
  logic [31:0] imem_inst, isr_inst;
  logic [31:0] inst, inst_pc, epc;
  logic        inst_valid, epc_we, in_isr;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = fill, 1 = run, 2 = handler
  int          m_mode;
  logic [31:0] m_pc, m_epc;
  logic        m_epc_we;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .intr_req       (intr_req),
    .imem_addr      (imem_addr),
    .isr_addr       (isr_addr),
    .imem_inst      (imem_inst),
    .isr_inst       (isr_inst),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .epc            (epc),
    .epc_we         (epc_we),
    .in_isr         (in_isr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] isr_word(input logic [29:0] a);
    return ~({2'b00, a} * 32'h85EB_CA6B) + 32'd7;
  endfunction

  always @(posedge clk) begin
    imem_inst <= imem_word(imem_addr);
    isr_inst  <= isr_word(isr_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_pc     = 32'h0000_0000;
    m_epc    = 32'h0000_0000;
    m_epc_we = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst",       inst,                32'd0);
    check("rst_inst_pc",    inst_pc,             32'd0);
    check("rst_epc",        epc,                 32'd0);
    check("rst_epc_we",     {31'b0, epc_we},     32'd0);
    check("rst_in_isr",     {31'b0, in_isr},     32'd0);
    check("rst_imem_addr",  {2'b00, imem_addr},  32'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic ir);
    logic        take, valid;
    logic [31:0] nxt, addr_pc, exp_inst;
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rp;
    intr_req       = ir;
    #1;
    take  = (m_mode == 1) && ir && !s && !r;
    valid = (m_mode != 0) && !take;
    if (m_mode == 0)  nxt = m_pc;
    else if (take)    nxt = 32'hC000_0000;
    else if (r)       nxt = {rp[31:2], 2'b00};
    else              nxt = m_pc + 32'd4;
    addr_pc = s ? m_pc : nxt;
    if (!valid)                     exp_inst = 32'h0;
    else if (m_pc[31:28] == 4'hC)   exp_inst = isr_word(m_pc[31:2]);
    else                            exp_inst = imem_word(m_pc[31:2]);
    check("inst_pc",    inst_pc,                m_pc);
    check("inst_valid", {31'b0, inst_valid},    {31'b0, valid});
    check("inst",       inst,                   exp_inst);
    check("imem_addr",  {2'b00, imem_addr},     {2'b00, addr_pc[31:2]});
    check("isr_addr",   {2'b00, isr_addr},      {2'b00, addr_pc[31:2]});
    check("epc",        epc,                    m_epc);
    check("epc_we",     {31'b0, epc_we},        {31'b0, m_epc_we});
    check("in_isr",     {31'b0, in_isr},        {31'b0, (m_mode == 2)});
    @(posedge clk);
    m_epc_we = take;
    if (!s) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (take) begin
        m_mode = 2;
        m_epc  = m_pc;
      end else if (m_mode == 2 && r && rp[31:28] != 4'hC) begin
        m_mode = 1;
      end
      m_pc = nxt;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom % 4)
      0:       return $urandom & 32'h0000_0FFF;
      1:       return 32'hC000_0000 | ($urandom & 32'h0000_00FF);
      2:       return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; intr_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Fill cycle, then sequential words up to 0x10
    repeat (5) step(0, 0, 32'h0, 0);
    // Stall held at 0x10
    repeat (3) step(1, 0, 32'h0, 0);
    // Run to 0x20 and take an interrupt there
    repeat (4) step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 1);
    // In handler: requests ignored, in-region jump, then return to 0x20
    repeat (2) step(0, 0, 32'h0, 1);
    step(0, 1, 32'hC000_0010, 1);
    step(0, 0, 32'h0, 1);
    step(0, 1, 32'h0000_0020, 0);
    repeat (2) step(0, 0, 32'h0, 0);
    // Interrupt coincident with redirect: deferred to the target
    step(0, 1, 32'h0000_0100, 1);
    step(0, 0, 32'h0, 1);
    repeat (2) step(0, 0, 32'h0, 0);
    // Stall and redirect together: stall wins
    step(1, 1, 32'h0000_0040, 0);
    step(0, 1, 32'h0000_0040, 0);
    // Sequential wrap at top of address space
    step(0, 1, 32'hFFFF_FFF8, 0);
    repeat (3) step(0, 0, 32'h0, 0);

    // Asynchronous reset in the middle of a handler
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    stall = 1'b0; redirect_valid = 1'b0; intr_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) step(0, 0, 32'h0, 0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 5) == 0, ($urandom % 5) == 0, rand_target(), ($urandom % 6) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined MIPS core; owns the PC, drives word addresses to both main instruction memory and the interrupt-service ROM, and returns the selected instruction with its PC to decode. Handles interrupt entry (redirect to the ISR region, EPC capture, squash) and ISR exit via a normal jump out of the region. Sits directly upstream of the ISR ROM and imem, which register the address on clk and return data one cycle later.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- ISR_BASE, 32'hC000_0000: interrupt entry PC; bits [31:28] identify the ISR region.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard stall from decode; hold PC and outputs.
- redirect_valid  in  1  branch/jump/jr target valid this cycle.
- redirect_pc  in  32  target PC (word aligned; bits [1:0] ignored).
- intr_req  in  1  level interrupt request from COP0.
- imem_addr  out  30  word address to imem.
- isr_addr  out  30  word address to ISR ROM (same value as imem_addr).
- imem_inst  in  32  imem data, one cycle after address.
- isr_inst  in  32  ISR ROM data, one cycle after address.
- inst  out  32  instruction to decode; 32'h0 when inst_valid=0.
- inst_pc  out  32  PC of inst.
- inst_valid  out  1  inst is to be issued.
- epc  out  32  saved return PC.
- epc_we  out  1  one-cycle pulse when epc is written (to COP0).
- in_isr  out  1  high while executing the handler.

## Operation
- State: pc_r, state ∈ {FILL, RUN, ISR}, epc, inst_valid_r.
- Address: imem_addr = isr_addr = stall ? pc_r[31:2] : pc_next[31:2]; memories re-latch same word while stalled.
- pc_next priority: interrupt entry → ISR_BASE; else redirect_valid → redirect_pc; else pc_r+4 (mod 2^32, wraps 32'hFFFF_FFFC → 0).
- Output mux: inst = (pc_r[31:28]==ISR_BASE[31:28]) ? isr_inst : imem_inst, gated to 0 when !inst_valid; inst_pc = pc_r.
- FILL: one cycle after reset release; inst_valid=0; → RUN.
- RUN: interrupt taken iff intr_req && !stall && !redirect_valid; otherwise deferred. On take: current instruction at pc_r squashed (inst_valid=0 next... see Timing), epc←pc_r, epc_we=1, → ISR.
- Redirect with no interrupt: instruction at pc_r is the delay slot, stays valid.
- ISR: intr_req ignored (no nesting). redirect_valid with redirect_pc[31:28] != ISR_BASE[31:28] → RUN (handler's jr $26). Redirects inside region stay in ISR.
- in_isr = (state==ISR).

## Timing
- Reset values: pc_r=RESET_PC, state=FILL, inst_valid=0, inst=0, epc=0, epc_we=0, in_isr=0; imem_addr=RESET_PC[31:2] during reset.
- Latency: address presented in cycle N → inst for it in cycle N+1 with inst_pc equal to that address.
- Interrupt taken at edge E: cycle before E outputs pc_r=P with inst_valid forced 0 (squash combinational on take condition); epc=P and epc_we=1 in cycle after E; pc_r=ISR_BASE, ISR word 0 valid in cycle after E.
- stall=1: pc_r, state, inst_valid, epc held; epc_we=0.
- stall and redirect_valid same cycle: stall wins; decode holds redirect.
- Reset mid-ISR: immediate asynchronous return to reset values; epc lost.

## Structure
- Package fetch_pkg: state enum, ISR_REGION = 4'hC, NOP = 32'h0, region-compare function.
- One natural sub-module: fetch_pc_sel (combinational pc_next priority mux + interrupt-take decision); rest in fetch_unit.

## Test plan
- Reset release, no stalls -> FILL cycle inst_valid=0; then inst_pc 0,4,8 with inst_valid=1; addresses 0,1,2,3.
- stall held 3 cycles at pc 0x10 -> imem_addr stays 0x4, inst/inst_pc unchanged, valid held.
- intr_req at pc_r=0x20 (no redirect) -> inst_valid=0 at 0x20, epc_we pulse with epc=0x20, next inst_pc=0xC0000000 from isr_inst, in_isr=1.
- intr_req coincident with redirect_valid to 0x100 -> no take that cycle; delay slot valid; taken next cycle with epc=0x100.
- In ISR, intr_req high, redirect to 0xC0000010 then to 0x20 -> stays ISR, then in_isr=0, inst_pc 0x20 from imem.
- rst_n asserted mid-ISR -> all outputs to reset values asynchronously; pc_r=0x00000000 after release.
